pc_run_controller: RTL

PC_RUN_CONTROLLER -- requirements
Module: pc_run_controller

---
 rtl/pc_run_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_run_controller.sv
// rtl/pc_run_controller.sv - program counter run/halt/load controller with button events and branch ticks
module pc_run_controller #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] STEP     = 16'h0001
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_count,
  input  logic        btn_stop,
  input  logic        btn_load_lo,
  input  logic        btn_load_hi,
  input  logic        btn_clr,
  input  logic [7:0]  sw,
  input  logic        branch_req,
  input  logic [7:0]  disp,
  output logic [15:0] pc,
  output logic        running,
  output logic        busy,
  output logic        load_done,
  output logic        wrap
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  state_t      ret_state;
  state_t      ret_next;

  logic [4:0]  btn_now;
  logic [4:0]  btn_prev;
  logic        evt_clr;
  logic        evt_lo;
  logic        evt_hi;
  logic        evt_stop;
  logic        evt_count;

  logic [15:0] rdest;
  logic [15:0] rdest_next;
  logic [15:0] pc_next;
  logic        load_done_next;
  logic        wrap_next;
  logic        running_next;
  logic        busy_next;

  logic [17:0] disp_ext;
  logic [17:0] tick_sum;

  assign btn_now   = {btn_clr, btn_load_lo, btn_load_hi, btn_stop, btn_count};
  assign evt_clr   = btn_now[4] & ~btn_prev[4];
  assign evt_lo    = btn_now[3] & ~btn_prev[3];
  assign evt_hi    = btn_now[2] & ~btn_prev[2];
  assign evt_stop  = btn_now[1] & ~btn_prev[1];
  assign evt_count = btn_now[0] & ~btn_prev[0];

  // 18-bit two's-complement sum: bit 17 flags a negative result, bit 16 a carry past 0xFFFF
  assign disp_ext = branch_req ? {{10{disp[7]}}, disp} : 18'd0;
  assign tick_sum = {2'b00, pc} + {2'b00, STEP} + disp_ext;

  always_ff @(posedge board_clk) begin : state_reg
    btn_prev <= btn_now;
    if (!reset) begin
      state   <= HALT;
      running <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      running <= running_next;
      busy    <= busy_next;
    end
  end

  always_comb begin : next_state_comb
    state_next = state;
    if (evt_clr) begin
      state_next = HALT;
    end else begin
      case (state)
        HALT: begin
          if (evt_lo || evt_hi) state_next = LOAD;
          else if (evt_count)   state_next = RUN;
        end
        RUN: begin
          if (evt_lo || evt_hi) state_next = LOAD;
          else if (evt_stop)    state_next = HALT;
        end
        LOAD:    state_next = ret_state;
        default: state_next = HALT;
      endcase
    end
  end

  // A count event while already running has no effect, so a coincident tick still applies
  always_comb begin : output_comb
    pc_next        = pc;
    rdest_next     = rdest;
    ret_next       = ret_state;
    load_done_next = 1'b0;
    wrap_next      = 1'b0;
    running_next   = (state_next == RUN);
    busy_next      = (state_next == LOAD);
    if (evt_clr) begin
      pc_next = PC_RESET;
    end else begin
      case (state)
        HALT, RUN: begin
          if (evt_lo) begin
            rdest_next = {pc[15:8], sw};
            ret_next   = state;
          end else if (evt_hi) begin
            rdest_next = {sw, pc[7:0]};
            ret_next   = state;
          end else if (state == RUN && !evt_stop && tick) begin
            pc_next   = tick_sum[15:0];
            wrap_next = |tick_sum[17:16];
          end
        end
        LOAD: begin
          pc_next        = rdest;
          load_done_next = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge board_clk) begin : datapath_reg
    if (!reset) begin
      pc        <= PC_RESET;
      rdest     <= 16'h0000;
      ret_state <= HALT;
      load_done <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      pc        <= pc_next;
      rdest     <= rdest_next;
      ret_state <= ret_next;
      load_done <= load_done_next;
      wrap      <= wrap_next;
    end
  end

endmodule
